// File: rtl/ece2300_latency_mem_pkg.sv
// ece2300_mem_pkg: shared definitions for the latency test memory.
//   MEMREQ_READ / MEMREQ_WRITE : request type encodings on memreq_type
//   state_e                    : response FSM states (IDLE, WAIT, RESP)
//   STATS_W / sat_inc          : width and saturating increment for the
//                                optional statistics counters
package ece2300_mem_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    localparam int STATS_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Counters hold at all-ones rather than wrapping.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ece2300_latency_mem_array.sv
// ece2300_mem_array: NUM_WORDS x WORD_BITS storage, synchronous write,
// combinational read, no reset (contents survive a reset of the controller).
//   clk      in  clock
//   we_i     in  write enable, committed at the rising edge
//   addr_i   in  word address (shared by read and write)
//   wdata_i  in  write data
//   rdata_o  out read data for addr_i; 0 for out-of-range addresses
module ece2300_mem_array #(
    parameter int NUM_WORDS = 256,
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = $clog2(NUM_WORDS)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    output logic [WORD_BITS-1:0] rdata_o
);

    logic [WORD_BITS-1:0] mem_q [NUM_WORDS];
    logic                 in_range;

    // With a power-of-two depth every address is legal, so the range
    // compare is only built for odd sizes.
    generate
        if (NUM_WORDS == (1 << ADDR_BITS)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_partial
            assign in_range = (32'(addr_i) < NUM_WORDS);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we_i && in_range) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = in_range ? mem_q[addr_i] : '0;

endmodule

// File: rtl/ece2300_latency_mem.sv
// ece2300_latency_mem: single-port test memory with a val/wait request
// interface and a per-request programmable response latency.
//   clk, reset          clock; asynchronous active-high reset
//   cfg_delay           extra wait cycles, captured when a request is accepted
//   memreq_val/_type    request valid; 0 = read, 1 = write
//   memreq_addr/_wdata  word address and write data
//   memresp_wait        low for exactly one cycle when the response is valid
//   memresp_data        read data in the response cycle, 0 otherwise
//   stat_reads/_writes  saturating accept counters, present only when
//                       ECE2300_LATENCY_MEM_STATS_EN is defined
module ece2300_latency_mem
    import ece2300_mem_pkg::*;
#(
    parameter int NUM_WORDS  = 256,
    parameter int WORD_BITS  = 32,
    parameter int DELAY_BITS = 4,
    parameter int ADDR_BITS  = $clog2(NUM_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DELAY_BITS-1:0] cfg_delay,
    input  logic                  memreq_val,
    input  logic                  memreq_type,
    input  logic [ADDR_BITS-1:0]  memreq_addr,
    input  logic [WORD_BITS-1:0]  memreq_wdata,
`ifdef ECE2300_LATENCY_MEM_STATS_EN
    output logic [STATS_W-1:0]    stat_reads,
    output logic [STATS_W-1:0]    stat_writes,
`endif
    output logic                  memresp_wait,
    output logic [WORD_BITS-1:0]  memresp_data
);

    state_e                state_q;
    logic [DELAY_BITS-1:0] cnt_q;
    logic [WORD_BITS-1:0]  resp_q;
    logic [WORD_BITS-1:0]  rd_data;
    logic                  accept;
    logic                  is_write;

    // Accepting in RESP lets a new request overlap the current response,
    // giving one request per cycle at zero delay.
    assign accept   = memreq_val && (state_q != WAIT);
    assign is_write = (memreq_type == MEMREQ_WRITE);

    ece2300_mem_array #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_BITS (WORD_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .we_i    (accept && is_write),
        .addr_i  (memreq_addr),
        .wdata_i (memreq_wdata),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else if (accept) begin
            // Read data is captured now, so a later write cannot alter it.
            resp_q  <= (memreq_type == MEMREQ_READ) ? rd_data : '0;
            cnt_q   <= cfg_delay;
            state_q <= (cfg_delay == '0) ? RESP : WAIT;
        end else begin
            case (state_q)
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == DELAY_BITS'(1)) begin
                        state_q <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memresp_wait = (state_q != RESP);
    assign memresp_data = (state_q == RESP) ? resp_q : '0;

`ifdef ECE2300_LATENCY_MEM_STATS_EN
    logic [STATS_W-1:0] stat_reads_q;
    logic [STATS_W-1:0] stat_writes_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else if (accept) begin
            if (is_write) stat_writes_q <= sat_inc(stat_writes_q);
            else          stat_reads_q  <= sat_inc(stat_reads_q);
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_ece2300_latency_mem.sv
// Bench for ece2300_latency_mem: directed scenarios followed by randomized
// traffic, checked every cycle against a timing/array reference model.
module tb_ece2300_latency_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  cfg_delay = '0;
    logic        memreq_val = 1'b0;
    logic        memreq_type = 1'b0;
    logic [7:0]  memreq_addr = '0;
    logic [31:0] memreq_wdata = '0;
    logic        memresp_wait;
    logic [31:0] memresp_data;
`ifdef ECE2300_LATENCY_MEM_STATS_EN
    logic [15:0] stat_reads;
    logic [15:0] stat_writes;
`endif

    always #5 clk = ~clk;

    ece2300_latency_mem dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_delay    (cfg_delay),
        .memreq_val   (memreq_val),
        .memreq_type  (memreq_type),
        .memreq_addr  (memreq_addr),
        .memreq_wdata (memreq_wdata),
`ifdef ECE2300_LATENCY_MEM_STATS_EN
        .stat_reads   (stat_reads),
        .stat_writes  (stat_writes),
`endif
        .memresp_wait (memresp_wait),
        .memresp_data (memresp_data)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: array contents plus the edge number after which the
    // single outstanding response is visible. A new request may be taken at
    // any edge strictly after the previous response edge.
    logic [31:0] mdl_mem [256];
    int          k = 0;
    int          resp_edge = -1;
    int          free_at = 0;
    logic [31:0] resp_val = '0;
    bit          accepted = 1'b0;
    int          n_rd = 0;
    int          n_wr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        k++;
        accepted = 1'b0;
        if (!reset && memreq_val && k >= free_at) begin
            accepted = 1'b1;
            if (memreq_type) begin
                mdl_mem[memreq_addr] = memreq_wdata;
                resp_val = '0;
                n_wr++;
            end else begin
                resp_val = mdl_mem[memreq_addr];
                n_rd++;
            end
            resp_edge = k + int'(cfg_delay);
            free_at   = resp_edge + 1;
        end
        @(negedge clk);
        chk("resp_wait", 32'(memresp_wait), (resp_edge == k) ? 32'd0 : 32'd1);
        chk("resp_data", memresp_data, (resp_edge == k) ? resp_val : 32'd0);
    endtask

    task automatic idle(input int n);
        memreq_val = 1'b0;
        repeat (n) cycle();
    endtask

    // Present a request and hold it until the model says it was taken.
    task automatic req(input bit wr, input int addr, input logic [31:0] wd,
                       input int dly, input bit jitter);
        memreq_val   = 1'b1;
        memreq_type  = wr;
        memreq_addr  = addr[7:0];
        memreq_wdata = wd;
        cfg_delay    = dly[3:0];
        for (int i = 0; i < 64; i++) begin
            if (jitter) cfg_delay = 4'($urandom_range(0, 4));
            cycle();
            if (accepted) return;
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_async_wait", 32'(memresp_wait), 32'd1);
        chk("rst_async_data", memresp_data, 32'd0);
        resp_edge = -1;
        free_at   = 0;
        n_rd      = 0;
        n_wr      = 0;
        memreq_val = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("reset_wait", 32'(memresp_wait), 32'd1);
        chk("reset_data", memresp_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Back-to-back writes of 10..13 to addresses 0..3 at zero delay.
        for (int i = 0; i < 4; i++) req(1'b1, i, 32'(10 + i), 0, 1'b0);

        // Write then read immediately at zero delay.
        req(1'b1, 5, 32'hDEADBEEF, 0, 1'b0);
        req(1'b0, 5, 32'h0, 0, 1'b0);
        idle(2);

        // Delay 3 read.
        req(1'b1, 7, 32'h42, 0, 1'b0);
        idle(2);
        req(1'b0, 7, 32'h0, 3, 1'b0);
        idle(5);

        // Back-to-back reads of 0..3.
        for (int i = 0; i < 4; i++) req(1'b0, i, 32'h0, 0, 1'b0);
        idle(2);

        // Second request held through WAIT; cfg_delay drops to 0 meanwhile.
        req(1'b0, 1, 32'h0, 2, 1'b0);
        req(1'b0, 2, 32'h0, 0, 1'b0);
        idle(3);

        // Reset while a read is waiting: the response must never appear.
        req(1'b0, 3, 32'h0, 5, 1'b0);
        idle(2);
        pulse_reset();
        idle(8);

        // Array retains pre-reset writes.
        req(1'b0, 5, 32'h0, 1, 1'b0);
        idle(3);

        // Fill the rest of the small working set, then random traffic.
        for (int i = 4; i < 16; i++) req(1'b1, i, $urandom, $urandom_range(0, 2), 1'b0);
        idle(1);
        for (int n = 0; n < 150; n++) begin
            req($urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom,
                ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
                $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(20);

`ifdef ECE2300_LATENCY_MEM_STATS_EN
        chk("stat_reads", 32'(stat_reads), 32'(n_rd));
        chk("stat_writes", 32'(stat_writes), 32'(n_wr));
        pulse_reset();
        chk("stat_reads_rst", 32'(stat_reads), 32'd0);
        chk("stat_writes_rst", 32'(stat_writes), 32'd0);
        for (int i = 0; i < 3; i++) req(1'b1, 20 + i, 32'(i), 0, 1'b0);
        for (int i = 0; i < 2; i++) req(1'b0, 20 + i, 32'h0, 0, 1'b0);
        idle(2);
        chk("stat_reads_2", 32'(stat_reads), 32'd2);
        chk("stat_writes_3", 32'(stat_writes), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", k);
        $fatal(1, "watchdog");
    end

endmodule
